// File: rtl/imem_arbiter.sv
// Arbitrates one single-port synchronous instruction memory between a fetch port
// (reads) and a loader port (writes), with a loader lock mode and a fetch-streak limit.
module imem_arbiter #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_SIZE         = 512,
  parameter int MAX_FETCH_STREAK = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        f_req_valid,
  input  logic [ADDRESS_WIDTH-1:0]    f_req_addr,
  output logic                        f_req_ready,
  input  logic                        f_flush,
  output logic                        f_rsp_valid,
  output logic [DATA_WIDTH-1:0]       f_rsp_instr,
  input  logic                        l_lock,
  input  logic                        l_req_valid,
  input  logic [ADDRESS_WIDTH-1:0]    l_req_addr,
  input  logic [DATA_WIDTH-1:0]       l_req_wdata,
  output logic                        l_req_ready,
  output logic                        lock_active,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
);

  localparam int IDX_W    = ADDRESS_WIDTH - 2;
  localparam int MEM_AW   = $clog2(MEM_SIZE);
  localparam int STREAK_W = $clog2(MAX_FETCH_STREAK + 1);
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [STREAK_W-1:0]  streak;
  logic                 rsp_pending;
  logic                 rsp_oor;
  logic                 f_grant, l_grant;
  logic                 streak_full;
  logic [IDX_W-1:0]     f_idx, l_idx;
  logic                 f_in_range, l_in_range;
  logic                 unused_addr_bits;

  assign f_idx            = f_req_addr[ADDRESS_WIDTH-1:2];
  assign l_idx            = l_req_addr[ADDRESS_WIDTH-1:2];
  assign unused_addr_bits = ^{f_req_addr[1:0], l_req_addr[1:0]};
  assign f_in_range       = 64'(f_idx) < 64'(MEM_SIZE);
  assign l_in_range       = 64'(l_idx) < 64'(MEM_SIZE);
  assign streak_full      = (streak == STREAK_W'(MAX_FETCH_STREAK));

  // Grant selection and lock transitions; nothing is granted while reset is held.
  // Lock is only taken on a cycle that launches no fetch, so LOCKED never owes a response.
  always_comb begin
    state_next = state;
    f_grant    = 1'b0;
    l_grant    = 1'b0;
    if (!rst) begin
      case (state)
        NORMAL: begin
          f_grant = f_req_valid && !(l_req_valid && streak_full);
          l_grant = l_req_valid && !f_grant;
          if (l_lock && !f_grant)
            state_next = LOCKED;
        end
        LOCKED: begin
          l_grant = l_req_valid;
          if (!l_lock)
            state_next = NORMAL;
        end
        default: state_next = NORMAL;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = MEM_AW'(f_idx);
    mem_wdata = l_req_wdata;
    if (l_grant) begin
      mem_en   = l_in_range;
      mem_we   = l_in_range;
      mem_addr = MEM_AW'(l_idx);
    end else if (f_grant) begin
      mem_en   = f_in_range;
    end
  end

  assign f_req_ready = f_grant;
  assign l_req_ready = l_grant;
  assign lock_active = (state == LOCKED);

  // Read data arrives straight from memory the cycle after the strobe; flush kills it.
  assign f_rsp_valid = rsp_pending && !f_flush;
  assign f_rsp_instr = !rsp_pending ? '0 : (rsp_oor ? NOP_INSTR : mem_rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NORMAL;
      streak      <= '0;
      rsp_pending <= 1'b0;
      rsp_oor     <= 1'b0;
    end else begin
      state       <= state_next;
      rsp_pending <= f_grant;
      rsp_oor     <= f_grant && !f_in_range;
      if (l_grant || !l_req_valid)
        streak <= '0;
      else if (f_grant && !streak_full)
        streak <= streak + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural single-port memory.
module tb_imem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 512;
  localparam int MA = $clog2(MS);

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req_valid, f_flush, l_lock, l_req_valid;
  logic [AW-1:0] f_req_addr, l_req_addr;
  logic [DW-1:0] l_req_wdata;
  logic          f_req_ready, f_rsp_valid, l_req_ready, lock_active, mem_en, mem_we;
  logic [DW-1:0] f_rsp_instr, mem_wdata, mem_rdata;
  logic [MA-1:0] mem_addr;
  logic [DW-1:0] model_mem [MS];

  int vectors   = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imem_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .MAX_FETCH_STREAK(4)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_instr(f_rsp_instr),
    .l_lock(l_lock), .l_req_valid(l_req_valid), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata), .l_req_ready(l_req_ready), .lock_active(lock_active),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port synchronous memory: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) model_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= model_mem[mem_addr];
    end
  end

  task automatic applyStimulus(input logic fv, input logic [AW-1:0] fa, input logic fl,
                               input logic lk, input logic lv, input logic [AW-1:0] la,
                               input logic [DW-1:0] lw);
    @(negedge clk);
    f_req_valid = fv; f_req_addr = fa; f_flush = fl;
    l_lock = lk; l_req_valid = lv; l_req_addr = la; l_req_wdata = lw;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < MS; i++) model_mem[i] = DW'(i);
    mem_rdata = '0;
    rst = 1'b1;
    f_req_valid = 0; f_req_addr = '0; f_flush = 0;
    l_lock = 0; l_req_valid = 0; l_req_addr = '0; l_req_wdata = '0;
    #12;
    checkOutput("rst_rsp_valid", 32'(f_rsp_valid), 32'd0);
    checkOutput("rst_rsp_instr", f_rsp_instr, 32'd0);
    checkOutput("rst_lock", 32'(lock_active), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back fetches of words 0,1,2
    applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("b2b_ready0", 32'(f_req_ready), 32'd1);
    checkOutput("b2b_en0", 32'({mem_en, mem_we}), 32'b10);
    checkOutput("b2b_valid0", 32'(f_rsp_valid), 32'd0);
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0);
    checkOutput("b2b_addr1", 32'(mem_addr), 32'd1);
    checkOutput("b2b_rsp1", 32'({f_rsp_valid, f_rsp_instr[3:0]}), 32'h10);
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0);
    checkOutput("b2b_rsp2", 32'({f_rsp_valid, f_rsp_instr[3:0]}), 32'h11);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("b2b_rsp3", 32'({f_rsp_valid, f_rsp_instr[3:0]}), 32'h12);
    checkOutput("idle_mem_en", 32'(mem_en), 32'd0);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("idle_rsp", 32'(f_rsp_valid), 32'd0);

    // Both ports continuously valid: F,F,F,F,L repeating
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'h0, 0, 0, 1, 32'h100, 32'h0000_00A5);
      checkOutput($sformatf("streak_f%0d", i), 32'(f_req_ready), (i % 5 == 4) ? 32'd0 : 32'd1);
      checkOutput($sformatf("streak_l%0d", i), 32'(l_req_ready), (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);

    // Memory boundary: last word in range, first word out of range
    applyStimulus(1, 32'h7FC, 0, 0, 0, 0, 0);
    checkOutput("last_word_en", 32'(mem_en), 32'd1);
    applyStimulus(1, 32'h800, 0, 0, 0, 0, 0);
    checkOutput("last_word_rsp", f_rsp_instr, 32'h1FF);
    checkOutput("oor_ready", 32'(f_req_ready), 32'd1);
    checkOutput("oor_no_en", 32'(mem_en), 32'd0);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h800, 32'h1234_5678);
    checkOutput("oor_nop", 32'({31'd0, f_rsp_valid}), 32'd1);
    checkOutput("oor_nop_instr", f_rsp_instr, 32'h0000_0013);
    checkOutput("oor_wr_ready", 32'(l_req_ready), 32'd1);
    checkOutput("oor_wr_drop", 32'({mem_en, mem_we}), 32'b00);

    // Lock requested while a fetch is in flight
    applyStimulus(1, 32'h10, 0, 1, 0, 0, 0);
    checkOutput("lk_fetch_ready", 32'(f_req_ready), 32'd1);
    checkOutput("lk_not_yet", 32'(lock_active), 32'd0);
    applyStimulus(0, 32'h0, 0, 1, 0, 0, 0);
    checkOutput("lk_rsp", f_rsp_instr, 32'd4);
    checkOutput("lk_rsp_cycle_unlocked", 32'(lock_active), 32'd0);
    applyStimulus(1, 32'h10, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    checkOutput("lk_active", 32'(lock_active), 32'd1);
    checkOutput("lk_f_blocked", 32'(f_req_ready), 32'd0);
    checkOutput("lk_l_ready", 32'(l_req_ready), 32'd1);
    checkOutput("lk_we", 32'({mem_en, mem_we}), 32'b11);
    checkOutput("lk_waddr", 32'(mem_addr), 32'd4);
    checkOutput("lk_wdata", mem_wdata, 32'hDEAD_BEEF);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("unlk_pending", 32'(lock_active), 32'd1);
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
    checkOutput("unlk_done", 32'(lock_active), 32'd0);
    checkOutput("unlk_fetch_ready", 32'(f_req_ready), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("readback", f_rsp_instr, 32'hDEAD_BEEF);

    // Flush: the response due in the flush cycle is dropped, the fetch taken then survives
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h4, 1, 0, 0, 0, 0);
    checkOutput("flush_drop", 32'(f_rsp_valid), 32'd0);
    checkOutput("flush_accept", 32'(f_req_ready), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("flush_same_cycle_rsp", 32'({f_rsp_valid, f_rsp_instr[3:0]}), 32'h11);

    // Reset asserted between edges with a fetch in flight
    applyStimulus(1, 32'hC, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(f_rsp_valid), 32'd0);
    checkOutput("mid_rst_instr", f_rsp_instr, 32'd0);
    checkOutput("mid_rst_en", 32'({mem_en, mem_we}), 32'b00);
    checkOutput("mid_rst_ready", 32'(f_req_ready), 32'd0);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);
    checkOutput("post_rst_no_stale", 32'(f_rsp_valid), 32'd0);
    checkOutput("post_rst_ready", 32'(f_req_ready), 32'd1);
    applyStimulus(0, 32'h0, 0, 1, 0, 0, 0);
    checkOutput("post_rst_rsp", 32'({f_rsp_valid, f_rsp_instr[3:0]}), 32'h15);
    applyStimulus(0, 32'h0, 0, 1, 0, 0, 0);
    checkOutput("relock", 32'(lock_active), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_clears_lock", 32'(lock_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
